// File: rtl/bp_cce_uncached_responder_pkg.sv
// Message formats for the uncached CCE responder.
// Holds the LCE request/response/command structs, the memory message struct
// with its echoed payload, and the two translation helpers used by the top.
// No ports: package only.
package bp_cce_uncached_responder_pkg;

  localparam int cce_id_width_p    = 3;
  localparam int lce_id_width_p    = 4;
  localparam int paddr_width_p     = 40;
  localparam int dword_width_p     = 64;
  localparam int cce_block_width_p = 128;
  localparam int size_width_p      = 4;

  typedef enum logic [1:0] {
    e_lce_req_type_rd        = 2'd0,
    e_lce_req_type_wr        = 2'd1,
    e_lce_req_uncached_load  = 2'd2,
    e_lce_req_uncached_store = 2'd3
  } bp_lce_cce_req_type_e;

  typedef enum logic [1:0] {
    e_cce_mem_rd    = 2'd0,
    e_cce_mem_wr    = 2'd1,
    e_cce_mem_uc_rd = 2'd2,
    e_cce_mem_uc_wr = 2'd3
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [1:0] {
    e_lce_cmd_sync       = 2'd0,
    e_lce_cmd_set_clear  = 2'd1,
    e_lce_cmd_uc_data    = 2'd2,
    e_lce_cmd_uc_st_done = 2'd3
  } bp_lce_cmd_type_e;

  typedef struct packed {
    bp_lce_cce_req_type_e        msg_type;
    logic [lce_id_width_p-1:0]   src_id;
    logic [size_width_p-1:0]     size;
    logic [paddr_width_p-1:0]    addr;
    logic [dword_width_p-1:0]    data;
  } bp_lce_cce_req_s;

  typedef struct packed {
    logic [lce_id_width_p-1:0]   src_id;
    logic [1:0]                  msg_type;
    logic [paddr_width_p-1:0]    addr;
  } bp_lce_cce_resp_s;

  // Echoed by memory so the response path needs no lookup table.
  typedef struct packed {
    logic [lce_id_width_p-1:0]   lce_id;
    bp_lce_cce_req_type_e        req_type;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    bp_cce_mem_cmd_type_e        msg_type;
    logic [size_width_p-1:0]     size;
    logic [paddr_width_p-1:0]    addr;
    bp_cce_mem_payload_s         payload;
    logic [cce_block_width_p-1:0] data;
  } bp_cce_mem_msg_s;

  typedef struct packed {
    bp_lce_cmd_type_e            msg_type;
    logic [lce_id_width_p-1:0]   dst_id;
    logic [cce_id_width_p-1:0]   src_id;
    logic [size_width_p-1:0]     size;
    logic [paddr_width_p-1:0]    addr;
    logic [cce_block_width_p-1:0] data;
  } bp_lce_cmd_s;

  // Uncached request -> memory command; stores carry their dword zero-extended.
  function automatic bp_cce_mem_msg_s lce_req_to_mem_cmd(input bp_lce_cce_req_s req);
    bp_cce_mem_msg_s cmd;
    cmd                  = '0;
    cmd.size             = req.size;
    cmd.addr             = req.addr;
    cmd.payload.lce_id   = req.src_id;
    cmd.payload.req_type = req.msg_type;
    case (req.msg_type)
      e_lce_req_uncached_store: begin
        cmd.msg_type = e_cce_mem_uc_wr;
        cmd.data     = {{(cce_block_width_p-dword_width_p){1'b0}}, req.data};
      end
      default: cmd.msg_type = e_cce_mem_uc_rd;
    endcase
    return cmd;
  endfunction

  // Memory response -> LCE command; only load data survives, stores return zero.
  function automatic bp_lce_cmd_s mem_resp_to_lce_cmd(input bp_cce_mem_msg_s resp,
                                                      input logic [cce_id_width_p-1:0] cce_id);
    bp_lce_cmd_s cmd;
    cmd        = '0;
    cmd.dst_id = resp.payload.lce_id;
    cmd.src_id = cce_id;
    cmd.size   = resp.size;
    cmd.addr   = resp.addr;
    case (resp.msg_type)
      e_cce_mem_uc_rd: begin
        cmd.msg_type = e_lce_cmd_uc_data;
        cmd.data     = {{(cce_block_width_p-dword_width_p){1'b0}}, resp.data[dword_width_p-1:0]};
      end
      default: cmd.msg_type = e_lce_cmd_uc_st_done;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/bp_cce_uncached_responder_checker.sv
// Non-synthesizing checker for the outstanding-transaction counter.
// Ports: clk_i/reset_i, count_i (current count), up_i/down_i (this cycle's
// increment and decrement). Flags any step past max_outstanding_p or below zero.
module bp_cce_uncached_responder_checker #(
  parameter int max_outstanding_p = 8,
  parameter int count_width_p     = 4
) (
  input logic                     clk_i,
  input logic                     reset_i,
  input logic [count_width_p-1:0] count_i,
  input logic                     up_i,
  input logic                     down_i
);

  overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(up_i && !down_i && (count_i == count_width_p'(max_outstanding_p))));

  underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(down_i && !up_i && (count_i == '0)));

endmodule

// File: rtl/bp_cce_uncached_responder_fifo.sv
// Two-entry valid/ready FIFO for translated LCE commands.
// Ports: clk_i/reset_i; enqueue side data_i, v_i, ready_o (ready = not full);
// dequeue side data_o, v_o, yumi_i (yumi only while v_o).
module bp_cce_uncached_responder_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] storage [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count;

  logic enq;
  logic deq;

  assign ready_o = (count != 2'd2);
  assign v_o     = (count != 2'd0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = storage[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      rd_ptr <= rd_ptr ^ deq;
      wr_ptr <= wr_ptr ^ enq;
      count  <= count + {1'b0, enq} - {1'b0, deq};
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      storage[wr_ptr] <= data_i;
    end
  end

endmodule

// File: rtl/bp_cce_uncached_responder.sv
// Uncached-only CCE endpoint: turns LCE uncached loads/stores into memory
// commands and memory responses back into uc_data / uc_st_done LCE commands.
// Ports: clk_i, reset_i (sync, active high), cce_id_i; lce_req_i/_v_i/_yumi_o;
// lce_resp_i/_v_i/_yumi_o (drained and ignored); lce_cmd_o/_v_o/_ready_i;
// mem_cmd_o/_v_o/_ready_i; mem_resp_i/_v_i/_yumi_o; error_o (sticky, cached
// request seen).
module bp_cce_uncached_responder
  import bp_cce_uncached_responder_pkg::*;
#(
  parameter int max_outstanding_p = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [cce_id_width_p-1:0] cce_id_i,
  input  bp_lce_cce_req_s           lce_req_i,
  input  logic                      lce_req_v_i,
  output logic                      lce_req_yumi_o,
  input  bp_lce_cce_resp_s          lce_resp_i,
  input  logic                      lce_resp_v_i,
  output logic                      lce_resp_yumi_o,
  output bp_lce_cmd_s               lce_cmd_o,
  output logic                      lce_cmd_v_o,
  input  logic                      lce_cmd_ready_i,
  output bp_cce_mem_msg_s           mem_cmd_o,
  output logic                      mem_cmd_v_o,
  input  logic                      mem_cmd_ready_i,
  input  bp_cce_mem_msg_s           mem_resp_i,
  input  logic                      mem_resp_v_i,
  output logic                      mem_resp_yumi_o,
  output logic                      error_o
);

  localparam int count_width_lp = $clog2(max_outstanding_p + 1);

  typedef enum logic {e_empty = 1'b0, e_full = 1'b1} req_state_e;

  req_state_e                state_r, state_n;
  bp_cce_mem_msg_s           mem_cmd_r, mem_cmd_n;
  logic [count_width_lp-1:0] count_r;
  logic                      error_r;

  logic req_uncached;
  logic mem_cmd_hs;
  logic count_avail;
  logic accept_uc;
  logic accept_cached;
  logic cmd_hs;
  logic fifo_ready;
  logic unused;

  // LCE responses and the unused parts of memory responses carry nothing we need.
  assign unused = ^{lce_resp_i, mem_resp_i};

  assign req_uncached = (lce_req_i.msg_type == e_lce_req_uncached_load)
                      | (lce_req_i.msg_type == e_lce_req_uncached_store);
  assign mem_cmd_v_o  = (state_r == e_full);
  assign mem_cmd_o    = mem_cmd_r;
  assign mem_cmd_hs   = mem_cmd_v_o & mem_cmd_ready_i;
  // Strict compare: a decrement in the same cycle does not free a slot early.
  assign count_avail  = (count_r < count_width_lp'(max_outstanding_p));

  assign lce_req_yumi_o  = ~reset_i & lce_req_v_i & ((state_r == e_empty) | mem_cmd_hs) & count_avail;
  assign lce_resp_yumi_o = ~reset_i & lce_resp_v_i;
  assign accept_uc       = lce_req_yumi_o & req_uncached;
  assign accept_cached   = lce_req_yumi_o & ~req_uncached;
  assign cmd_hs          = lce_cmd_v_o & lce_cmd_ready_i;
  assign error_o         = error_r;

  // Request register next state: load on accept, release on memory handshake.
  always_comb begin
    state_n   = state_r;
    mem_cmd_n = mem_cmd_r;
    unique case (state_r)
      e_empty: begin
        if (accept_uc) begin
          state_n   = e_full;
          mem_cmd_n = lce_req_to_mem_cmd(lce_req_i);
        end else begin
          state_n   = e_empty;
        end
      end
      e_full: begin
        if (accept_uc) begin
          mem_cmd_n = lce_req_to_mem_cmd(lce_req_i);
        end else if (mem_cmd_hs) begin
          state_n   = e_empty;
        end else begin
          state_n   = e_full;
        end
      end
      default: state_n = e_empty;
    endcase
  end

  // Request register, outstanding counter and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= e_empty;
      mem_cmd_r <= '0;
      count_r   <= '0;
      error_r   <= 1'b0;
    end else begin
      state_r   <= state_n;
      mem_cmd_r <= mem_cmd_n;
      count_r   <= count_r + count_width_lp'(accept_uc) - count_width_lp'(cmd_hs);
      error_r   <= error_r | accept_cached;
    end
  end

  assign mem_resp_yumi_o = ~reset_i & mem_resp_v_i & fifo_ready;

  bp_cce_uncached_responder_fifo #(
    .width_p ($bits(bp_lce_cmd_s))
  ) resp_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (mem_resp_to_lce_cmd(mem_resp_i, cce_id_i)),
    .v_i     (mem_resp_yumi_o),
    .ready_o (fifo_ready),
    .data_o  (lce_cmd_o),
    .v_o     (lce_cmd_v_o),
    .yumi_i  (cmd_hs)
  );

  bp_cce_uncached_responder_checker #(
    .max_outstanding_p (max_outstanding_p),
    .count_width_p     (count_width_lp)
  ) count_checker (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .count_i (count_r),
    .up_i    (accept_uc),
    .down_i  (cmd_hs)
  );

endmodule

// File: tb/tb_bp_cce_uncached_responder.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared cycle by cycle against a transaction-level reference model.
module tb_bp_cce_uncached_responder;
  import bp_cce_uncached_responder_pkg::*;

  localparam int MAX = 3;

  logic                      clk;
  logic                      reset;
  logic [cce_id_width_p-1:0] cce_id;
  bp_lce_cce_req_s           lce_req;
  logic                      lce_req_v;
  logic                      lce_req_yumi_o;
  bp_lce_cce_resp_s          lce_resp;
  logic                      lce_resp_v;
  logic                      lce_resp_yumi_o;
  bp_lce_cmd_s               lce_cmd_o;
  logic                      lce_cmd_v_o;
  logic                      lce_cmd_ready;
  bp_cce_mem_msg_s           mem_cmd_o;
  logic                      mem_cmd_v_o;
  logic                      mem_cmd_ready;
  bp_cce_mem_msg_s           mem_resp;
  logic                      mem_resp_v;
  logic                      mem_resp_yumi_o;
  logic                      error_o;

  bp_cce_uncached_responder #(.max_outstanding_p(MAX)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .cce_id_i        (cce_id),
    .lce_req_i       (lce_req),
    .lce_req_v_i     (lce_req_v),
    .lce_req_yumi_o  (lce_req_yumi_o),
    .lce_resp_i      (lce_resp),
    .lce_resp_v_i    (lce_resp_v),
    .lce_resp_yumi_o (lce_resp_yumi_o),
    .lce_cmd_o       (lce_cmd_o),
    .lce_cmd_v_o     (lce_cmd_v_o),
    .lce_cmd_ready_i (lce_cmd_ready),
    .mem_cmd_o       (mem_cmd_o),
    .mem_cmd_v_o     (mem_cmd_v_o),
    .mem_cmd_ready_i (mem_cmd_ready),
    .mem_resp_i      (mem_resp),
    .mem_resp_v_i    (mem_resp_v),
    .mem_resp_yumi_o (mem_resp_yumi_o),
    .error_o         (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: issued-but-unsent memory command, memory's pending
  // replies, commands waiting for the LCE, in-flight count, sticky error.
  bp_cce_mem_msg_s pend_q[$];
  bp_cce_mem_msg_s mem_q[$];
  bp_lce_cmd_s     fifo_q[$];
  int              outstanding = 0;
  bit              err = 1'b0;
  bit              resp_en = 1'b0;
  bit              override_v = 1'b0;
  logic [cce_block_width_p-1:0] override_data;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bp_cce_mem_msg_s model_mem_cmd(input bp_lce_cce_req_s q);
    bp_cce_mem_msg_s m;
    m = '0;
    m.msg_type = (q.msg_type == e_lce_req_uncached_store) ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
    m.size = q.size;
    m.addr = q.addr;
    m.payload.lce_id = q.src_id;
    m.payload.req_type = q.msg_type;
    if (q.msg_type == e_lce_req_uncached_store) m.data[dword_width_p-1:0] = q.data;
    return m;
  endfunction

  function automatic bp_lce_cmd_s model_lce_cmd(input bp_cce_mem_msg_s r);
    bp_lce_cmd_s c;
    c = '0;
    c.dst_id = r.payload.lce_id;
    c.src_id = cce_id;
    c.size = r.size;
    c.addr = r.addr;
    if (r.msg_type == e_cce_mem_uc_rd) begin
      c.msg_type = e_lce_cmd_uc_data;
      c.data[dword_width_p-1:0] = r.data[dword_width_p-1:0];
    end else begin
      c.msg_type = e_lce_cmd_uc_st_done;
    end
    return c;
  endfunction

  // One clock cycle: drive memory side, compare outputs, advance the model.
  task automatic step();
    bit exp_mem_v, exp_lce_v, mem_hs, cmd_hs, exp_req_yumi, exp_resp_yumi, uc;
    bp_cce_mem_msg_s r;
    mem_resp_v = resp_en && !reset && (mem_q.size() > 0);
    mem_resp   = (mem_q.size() > 0) ? mem_q[0] : '0;
    #1;
    exp_mem_v     = (pend_q.size() > 0);
    exp_lce_v     = (fifo_q.size() > 0);
    mem_hs        = exp_mem_v && mem_cmd_ready;
    cmd_hs        = exp_lce_v && lce_cmd_ready;
    uc            = (lce_req.msg_type == e_lce_req_uncached_load) ||
                    (lce_req.msg_type == e_lce_req_uncached_store);
    exp_req_yumi  = !reset && lce_req_v && (!exp_mem_v || mem_hs) && (outstanding < MAX);
    exp_resp_yumi = mem_resp_v && (fifo_q.size() < 2);
    check("req_yumi", 256'(lce_req_yumi_o), 256'(exp_req_yumi));
    check("resp_yumi", 256'(lce_resp_yumi_o), 256'(lce_resp_v && !reset));
    check("mem_cmd_v", 256'(mem_cmd_v_o), 256'(exp_mem_v));
    check("mem_resp_yumi", 256'(mem_resp_yumi_o), 256'(exp_resp_yumi));
    check("lce_cmd_v", 256'(lce_cmd_v_o), 256'(exp_lce_v));
    check("error", 256'(error_o), 256'(err));
    if (exp_mem_v) check("mem_cmd", 256'(mem_cmd_o), 256'(pend_q[0]));
    if (exp_lce_v) check("lce_cmd", 256'(lce_cmd_o), 256'(fifo_q[0]));
    if (reset) begin
      pend_q.delete(); mem_q.delete(); fifo_q.delete();
      outstanding = 0; err = 1'b0; override_v = 1'b0;
    end else begin
      if (mem_hs) begin
        r = pend_q.pop_front();
        r.data = override_v ? override_data : {$urandom, $urandom, $urandom, $urandom};
        override_v = 1'b0;
        mem_q.push_back(r);
      end
      if (exp_resp_yumi) fifo_q.push_back(model_lce_cmd(mem_q.pop_front()));
      if (cmd_hs) begin
        void'(fifo_q.pop_front());
        outstanding--;
      end
      if (exp_req_yumi) begin
        if (uc) begin
          pend_q.push_back(model_mem_cmd(lce_req));
          outstanding++;
        end else begin
          err = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    lce_req_v = 1'b0; lce_resp_v = 1'b0; resp_en = 1'b0;
    mem_cmd_ready = 1'b1; lce_cmd_ready = 1'b1;
  endtask

  task automatic set_req(input bp_lce_cce_req_type_e t, input int lce, input logic [39:0] a,
                         input int sz, input logic [63:0] d);
    lce_req.msg_type = t;
    lce_req.src_id   = lce_id_width_p'(lce);
    lce_req.addr     = a;
    lce_req.size     = size_width_p'(sz);
    lce_req.data     = d;
  endtask

  initial begin
    cce_id = 3'd5;
    lce_req = '0; lce_resp = '0; mem_resp = '0; mem_resp_v = 1'b0;
    idle();
    reset = 1'b1;
    @(negedge clk);
    step(); step();
    reset = 1'b0;
    step();
    check("rst_mem_v", 256'(mem_cmd_v_o), 256'(0));
    check("rst_lce_v", 256'(lce_cmd_v_o), 256'(0));
    check("rst_error", 256'(error_o), 256'(0));

    // Uncached load with a response whose upper bits must be dropped.
    set_req(e_lce_req_uncached_load, 1, 40'h00_8000_0040, 8, 64'h0);
    lce_req_v = 1'b1;
    step();
    lce_req_v = 1'b0;
    check("ld_mem_v", 256'(mem_cmd_v_o), 256'(1));
    check("ld_mem_type", 256'(mem_cmd_o.msg_type), 256'(e_cce_mem_uc_rd));
    check("ld_mem_addr", 256'(mem_cmd_o.addr), 256'(40'h00_8000_0040));
    override_v = 1'b1;
    override_data = 128'hFFFF_0000_1111_2222_DEAD_BEEF_CAFE_F00D;
    step();
    resp_en = 1'b1;
    step();
    check("ld_cmd_v", 256'(lce_cmd_v_o), 256'(1));
    check("ld_cmd_type", 256'(lce_cmd_o.msg_type), 256'(e_lce_cmd_uc_data));
    check("ld_cmd_dst", 256'(lce_cmd_o.dst_id), 256'(1));
    check("ld_cmd_data", 256'(lce_cmd_o.data), 256'(128'hDEAD_BEEF_CAFE_F00D));
    step();
    resp_en = 1'b0;
    check("ld_drained", 256'(lce_cmd_v_o), 256'(0));

    // Uncached store.
    set_req(e_lce_req_uncached_store, 2, 40'h10, 3, 64'h1234);
    lce_req_v = 1'b1;
    step();
    lce_req_v = 1'b0;
    check("st_mem_type", 256'(mem_cmd_o.msg_type), 256'(e_cce_mem_uc_wr));
    check("st_mem_data", 256'(mem_cmd_o.data), 256'(128'h1234));
    step();
    resp_en = 1'b1;
    step();
    check("st_cmd_type", 256'(lce_cmd_o.msg_type), 256'(e_lce_cmd_uc_st_done));
    check("st_cmd_data", 256'(lce_cmd_o.data), 256'(0));
    step();

    // Outstanding limit: responses withheld, back-to-back loads.
    idle();
    set_req(e_lce_req_uncached_load, 3, 40'h200, 8, 64'h0);
    lce_req_v = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("limit_blocked", 256'(lce_req_yumi_o), 256'(0));
    resp_en = 1'b1;
    for (int i = 0; i < 8; i++) step();
    lce_req_v = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Command backpressure with three responses pending.
    idle();
    lce_cmd_ready = 1'b0;
    lce_req_v = 1'b1;
    for (int i = 0; i < 3; i++) step();
    lce_req_v = 1'b0;
    for (int i = 0; i < 2; i++) step();
    resp_en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("bp_mem_resp_v", 256'(mem_resp_v), 256'(1));
    check("bp_yumi_low", 256'(mem_resp_yumi_o), 256'(0));
    lce_cmd_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Cached request: dropped, error latched.
    idle();
    set_req(e_lce_req_type_rd, 1, 40'h300, 8, 64'h0);
    lce_req_v = 1'b1;
    step();
    lce_req_v = 1'b0;
    check("cached_err", 256'(error_o), 256'(1));
    check("cached_no_cmd", 256'(mem_cmd_v_o), 256'(0));
    step();

    // Reset with two transactions outstanding.
    set_req(e_lce_req_uncached_load, 4, 40'h400, 8, 64'h0);
    lce_req_v = 1'b1;
    step(); step();
    lce_req_v = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("mid_rst_mem_v", 256'(mem_cmd_v_o), 256'(0));
    check("mid_rst_lce_v", 256'(lce_cmd_v_o), 256'(0));
    check("mid_rst_error", 256'(error_o), 256'(0));
    reset = 1'b0;
    resp_en = 1'b1;
    step(); step();

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 599) == 0);
      lce_req_v = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0)
        lce_req.msg_type = bp_lce_cce_req_type_e'(2'($urandom_range(0, 1)));
      else
        lce_req.msg_type = bp_lce_cce_req_type_e'(2'($urandom_range(2, 3)));
      lce_req.src_id = lce_id_width_p'($urandom_range(0, 15));
      lce_req.size   = size_width_p'($urandom_range(0, 15));
      lce_req.addr   = paddr_width_p'({$urandom, $urandom});
      lce_req.data   = {$urandom, $urandom};
      lce_resp.addr  = paddr_width_p'({$urandom, $urandom});
      lce_resp_v     = $urandom_range(0, 1);
      mem_cmd_ready  = ($urandom_range(0, 3) != 0);
      lce_cmd_ready  = ($urandom_range(0, 3) != 0);
      resp_en        = ($urandom_range(0, 2) != 0);
      cce_id         = 3'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
